// File: rtl/rrat_if.sv
// Commit-side bundles between the ROB, the retirement alias table and the RAT.
`ifndef RRAT_GLOBALS
`define RRAT_GLOBALS
`define N 4
`define ARCH_REG_SZ 32
`define PHYS_REG_SZ_R10K 64
`define ZERO_REG 0
`define FREE_LIST_CTR_WIDTH 7
`endif

interface rrat_if #(
  parameter int SIZE = `ARCH_REG_SZ
) ();
  localparam int PHYS  = `PHYS_REG_SZ_R10K;
  localparam int PRN_W = $clog2(PHYS);
  localparam int ARN_W = $clog2(SIZE);
  localparam int CTR_W = `FREE_LIST_CTR_WIDTH;

  typedef struct packed {
    logic             valid;
    logic [ARN_W-1:0] arn;
    logic [PRN_W-1:0] prn;
  } ct_entry_t;

  typedef struct packed {
    ct_entry_t [`N-1:0] entries;
    logic               squash;
  } rrat_ct_input_t;

  typedef struct packed {
    logic             valid;
    logic [PRN_W-1:0] prn;
  } free_list_packet_t;

  typedef struct packed {
    logic [SIZE-1:0][PRN_W-1:0] entries;
    free_list_packet_t [`N-1:0] free_packet;
    logic [PHYS-1:0][PRN_W-1:0] free_list;
    logic [PRN_W-1:0]           head;
    logic [PRN_W-1:0]           tail;
    logic [CTR_W-1:0]           free_list_counter;
    logic                       squash;
  } rrat_ct_output_t;

  rrat_ct_input_t  rrat_ct_input;
  rrat_ct_output_t rrat_ct_output;

  // ROB side drives commits and may observe the RAT-bound bundle
  modport master (output rrat_ct_input, input rrat_ct_output);
  // retirement table consumes commits and produces the RAT-bound bundle
  modport slave  (input rrat_ct_input, output rrat_ct_output);
endinterface

// File: rtl/rrat.sv
// Retirement register alias table: committed arch->phys map plus a shadow of
// the RAT free list, with a one-cycle snapshot hand-back on squash.
`ifndef RRAT_GLOBALS
`define RRAT_GLOBALS
`define N 4
`define ARCH_REG_SZ 32
`define PHYS_REG_SZ_R10K 64
`define ZERO_REG 0
`define FREE_LIST_CTR_WIDTH 7
`endif

module rrat #(
  parameter int SIZE = `ARCH_REG_SZ
) (
  input  logic   clock,
  input  logic   reset,
  rrat_if.slave  ct
);
  localparam int PHYS  = `PHYS_REG_SZ_R10K;
  localparam int PRN_W = $clog2(PHYS);
  localparam int ARN_W = $clog2(SIZE);
  localparam int CTR_W = `FREE_LIST_CTR_WIDTH;

  logic [PRN_W-1:0] tbl     [SIZE];
  logic [PRN_W-1:0] fl      [PHYS];
  logic [PRN_W-1:0] head, tail;
  logic [CTR_W-1:0] counter;
  logic [`N-1:0]    fp_valid;
  logic [PRN_W-1:0] fp_prn  [`N];
  logic             squash_q;

  logic [PRN_W-1:0] tbl_n   [SIZE];
  logic [PRN_W-1:0] fl_n    [PHYS];
  logic [PRN_W-1:0] head_n, tail_n, span_n, old_prn;
  logic [`N-1:0]    fp_valid_n;
  logic [PRN_W-1:0] fp_prn_n [`N];

  // Apply all commit slots in order; later slots see earlier slots' updates
  always_comb begin
    tbl_n      = tbl;
    fl_n       = fl;
    head_n     = head;
    tail_n     = tail;
    old_prn    = '0;
    fp_valid_n = '0;
    for (int i = 0; i < `N; i++) fp_prn_n[i] = '0;
    for (int i = 0; i < `N; i++) begin
      if (ct.rrat_ct_input.entries[i].valid &&
          ct.rrat_ct_input.entries[i].arn != ARN_W'(`ZERO_REG)) begin
        old_prn = tbl_n[ct.rrat_ct_input.entries[i].arn];
        tbl_n[ct.rrat_ct_input.entries[i].arn] = ct.rrat_ct_input.entries[i].prn;
        fl_n[tail_n] = old_prn;
        tail_n = tail_n + 1'b1;
        head_n = head_n + 1'b1;
        // frees folded into a squash snapshot must not reach the RAT twice
        if (!ct.rrat_ct_input.squash) begin
          fp_valid_n[i] = 1'b1;
          fp_prn_n[i]   = old_prn;
        end
      end
    end
    span_n = tail_n - head_n;
  end

  // Committed state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) tbl[i] <= PRN_W'(i);
      for (int j = 0; j < PHYS; j++) fl[j] <= (j < PHYS - SIZE) ? PRN_W'(SIZE + j) : '0;
      head     <= '0;
      tail     <= PRN_W'(PHYS - SIZE);
      counter  <= CTR_W'(PHYS - SIZE);
      fp_valid <= '0;
      for (int i = 0; i < `N; i++) fp_prn[i] <= '0;
      squash_q <= 1'b0;
    end else begin
      tbl      <= tbl_n;
      fl       <= fl_n;
      head     <= head_n;
      tail     <= tail_n;
      counter  <= CTR_W'(span_n);
      fp_valid <= fp_valid_n;
      fp_prn   <= fp_prn_n;
      squash_q <= ct.rrat_ct_input.squash;
    end
  end

  // Pack registered state onto the RAT-bound bundle
  always_comb begin
    ct.rrat_ct_output = '0;
    for (int i = 0; i < SIZE; i++) ct.rrat_ct_output.entries[i] = tbl[i];
    for (int j = 0; j < PHYS; j++) ct.rrat_ct_output.free_list[j] = fl[j];
    for (int i = 0; i < `N; i++) begin
      ct.rrat_ct_output.free_packet[i].valid = fp_valid[i];
      ct.rrat_ct_output.free_packet[i].prn   = fp_prn[i];
    end
    ct.rrat_ct_output.head              = head;
    ct.rrat_ct_output.tail              = tail;
    ct.rrat_ct_output.free_list_counter = counter;
    ct.rrat_ct_output.squash            = squash_q;
  end
endmodule

// File: doc/rrat.md
# rrat

Retirement register alias table: commit-side counterpart of the rename-stage RAT. It holds the architectural-to-physical map for committed state and returns each overwritten physical register to the RAT free list. It also keeps a committed-state shadow of that free list (array, head, tail, counter). On a commit-time squash it hands the whole committed map and free-list snapshot back to the RAT in one registered cycle. It sits between the ROB commit port and the RAT.

## Interface
- SIZE, `ARCH_REG_SZ, number of architectural registers / map entries
- `N (global), commit/rename width
- `PHYS_REG_SZ_R10K (global), physical register count; power of two, greater than SIZE
- clock  input  1  system clock
- reset  input  1  reset: synchronous, active-high
- rrat_ct_input  input  RRAT_CT_INPUT  commit bundle from ROB
  - entries[`N]: {valid, arn, prn}
  - squash: 1 when the last valid slot is a mispredicted instruction
- rrat_ct_output  output  RRAT_CT_OUTPUT  bundle to RAT
  - entries[SIZE] PRN
  - free_packet[`N] FREE_LIST_PACKET {valid, prn}
  - free_list[`PHYS_REG_SZ_R10K] PRN
  - head, tail: PRN-width pointers
  - free_list_counter: `FREE_LIST_CTR_WIDTH
  - squash: 1

## Operation
- State: map table[SIZE], free list array fl[PHYS], head, tail, counter. All outputs are driven from registers.
- Reset values:
  - table[i] = i.
  - fl[j] = SIZE+j for j < PHYS−SIZE; otherwise 0.
  - head = 0, tail = PHYS−SIZE (mod PHYS), counter = PHYS−SIZE.
  - free_packet all invalid, squash = 0.
- Commit, per slot i in ascending order within one cycle:
  - If valid and arn != `ZERO_REG: old = current table[arn], where current includes earlier slots of the same cycle.
  - Then table[arn] = prn, fl[tail] = old, tail+1, head+1; free slot i carries {1, old}.
  - Slots that are invalid or target ZERO_REG make no change, and their free slot is {0, 0}.
- Pointers wrap modulo PHYS.
- Counter is recomputed as the number of entries from head to tail. It equals PHYS−SIZE in every legal state; a differing value is a bug for verification to flag.
- Same arn in several slots of one cycle: the updates chain. The second slot frees the first slot's prn, and the final map is the last slot's prn.
- Squash:
  - The commits present in the squash cycle are applied first.
  - Next cycle, output squash = 1 and entries/free_list/head/tail/counter reflect the post-commit state.
  - In that cycle, free_packet is all invalid. Those frees are already in the snapshot, so the RAT must not see them twice.
- Commits arriving while output squash = 1 are processed normally; the ROB sends none after a flush.
- Slots after the squashing slot are guaranteed invalid by the ROB; rrat does not check.

## Timing
- Commit in cycle t updates the table/pointers at the edge ending t; the outputs show it in t+1.
- free_packet is valid for exactly one cycle, t+1, unless squash is asserted in that cycle.
- The squash output pulse is exactly one cycle (t+1) per input squash cycle. A squash on consecutive input cycles gives consecutive pulses.
- No backpressure; a full commit width is accepted every cycle.
- Reset asserted in any cycle, including a squash output cycle, restores all reset values at that edge. No squash or free is emitted afterward.

## Test plan
- Reset (SIZE=32, PHYS=64) -> entries[i]=i, head=0, tail=32, counter=32, fl[0]=32, fl[31]=63, squash=0, all free invalid.
- Commit {arn 3, prn 32} in slot 0 -> next cycle:
  - entries[3]=32, free_packet[0]={1,3}, fl[32]=3, head=1, tail=33.
  - One cycle later, free_packet is invalid.
- One cycle: slot0 {5,33}, slot1 {5,34} -> entries[5]=34, free_packet[0]={1,5}, free_packet[1]={1,33}, tail+2, head+2.
- Commit with arn=`ZERO_REG plus an invalid slot -> table, head, tail and counter unchanged; free packets invalid.
- Slot0 {7,40} with squash=1 -> next cycle:
  - squash=1, entries[7]=40, fl snapshot contains 7 at the old tail.
  - free_packet all invalid; squash drops the following cycle.
- 32 single commits from reset -> tail wraps 63→0, head reaches 32, and counter stays 32 throughout. Then reset in a squash output cycle restores the reset values on the next edge.
